// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the two cache front-ends and the RAM.
// The arbiter uses the slave view; the cache/RAM side uses the master view.
interface mem_arbiter_if;
    // icache side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    // dcache side
    logic        dREN;
    logic        dWEN;
    logic        datomic;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    // RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (icache / dcache) in front of a single RAM port.
// dcache has priority, bounded by a starvation counter so icache is forced
// through after STARVE_MAX back-to-back dcache grants. Supports LL/SC through
// a single link register. RAM strobes and return data are decoded from the
// state register and the current RAM status so a completion is seen in the
// same cycle the RAM reports ACCESS.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam int              CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [1:0]      RS_ACCESS  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        SCFAIL = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          link_valid_q, link_valid_d;
    logic [31:0]   link_addr_q, link_addr_d;
    logic [CW-1:0] starve_q, starve_d;

    logic d_pend_s;
    logic is_sc_s;
    logic link_hit_s;
    logic access_s;
    logic i_done_s;
    logic d_done_s;

    assign d_pend_s   = bus.dREN | bus.dWEN;
    // Both strobes high is a write, so atomic+write is always SC.
    assign is_sc_s    = bus.dWEN & bus.datomic;
    assign link_hit_s = link_valid_q & (link_addr_q == bus.daddr);
    assign access_s   = (bus.ramstate == RS_ACCESS);

    assign bus.iwait = bus.iREN & ~((state_q == IGRANT) & access_s);
    assign bus.dwait = d_pend_s & ~((state_q == DGRANT) & access_s) & ~(state_q == SCFAIL);

    // State, link and starvation registers; reset may hit mid-grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            link_valid_q <= 1'b0;
            link_addr_q  <= 32'd0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            starve_q     <= starve_d;
        end
    end

    // Next-state, link update and RAM/return-data decode.
    always_comb begin
        state_d      = state_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        i_done_s     = 1'b0;
        d_done_s     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        bus.iload    = 32'd0;
        bus.dload    = 32'd0;

        case (state_q)
            IDLE: begin
                if (d_pend_s && ((starve_q < STARVE_LIM) || !bus.iREN)) begin
                    // A doomed SC is answered without touching the RAM.
                    if (is_sc_s && !link_hit_s) begin
                        state_d = SCFAIL;
                    end else begin
                        state_d = DGRANT;
                    end
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end else begin
                    state_d = IDLE;
                end
            end

            IGRANT: begin
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (access_s) begin
                        bus.iload = bus.ramload;
                        i_done_s  = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = IGRANT;
                    end
                end
            end

            DGRANT: begin
                if (!d_pend_s) begin
                    state_d = IDLE;
                end else begin
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    if (access_s) begin
                        d_done_s = 1'b1;
                        state_d  = IDLE;
                        if (is_sc_s) begin
                            bus.dload    = 32'd1;
                            link_valid_d = 1'b0;
                        end else if (bus.dWEN) begin
                            // A plain store to the linked word breaks the link.
                            if (bus.daddr == link_addr_q) begin
                                link_valid_d = 1'b0;
                            end else begin
                                link_valid_d = link_valid_q;
                            end
                        end else begin
                            bus.dload = bus.ramload;
                            if (bus.datomic) begin
                                link_valid_d = 1'b1;
                                link_addr_d  = bus.daddr;
                            end else begin
                                link_valid_d = link_valid_q;
                            end
                        end
                    end else begin
                        state_d = DGRANT;
                    end
                end
            end

            SCFAIL: begin
                link_valid_d = 1'b0;
                d_done_s     = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter: counts dcache completions that overtook a waiting icache.
    always_comb begin
        starve_d = starve_q;
        if (!bus.iREN || i_done_s) begin
            starve_d = '0;
        end else if (d_done_s && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            starve_d = starve_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.
module tb_mem_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.datomic  = 1'b0;
        bus.ramstate = RS_FREE;
    endtask

    // Issue one dcache request against an always-ACCESS RAM: IDLE cycle, then completion cycle.
    task automatic d_xfer(input logic wen, input logic atomic, input logic [31:0] addr,
                          input logic [31:0] data);
        bus.dREN     = ~wen;
        bus.dWEN     = wen;
        bus.datomic  = atomic;
        bus.daddr    = addr;
        bus.dstore   = data;
        bus.ramstate = RS_ACCESS;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.iaddr   = 32'd0;
        bus.daddr   = 32'd0;
        bus.dstore  = 32'd0;
        bus.ramload = 32'd0;
        idle_inputs();

        // Reset state
        #3;
        chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("rst_iload",  bus.iload, 32'd0);
        chk("rst_dload",  bus.dload, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // icache read, BUSY x2 then ACCESS
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0040;
        bus.ramstate = RS_BUSY;
        bus.ramload  = 32'h8C01_0004;
        mid();
        chk("i_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("i_idle_iwait",  {31'd0, bus.iwait},  32'd1);
        tick();
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("i_busy_ramREN",  {31'd0, bus.ramREN}, 32'd1);
            chk("i_busy_ramaddr", bus.ramaddr, 32'h0000_0040);
            chk("i_busy_iwait",   {31'd0, bus.iwait},  32'd1);
            chk("i_busy_iload",   bus.iload, 32'd0);
            tick();
        end
        bus.ramstate = RS_ACCESS;
        mid();
        chk("i_acc_ramREN", {31'd0, bus.ramREN}, 32'd1);
        chk("i_acc_iwait",  {31'd0, bus.iwait},  32'd0);
        chk("i_acc_iload",  bus.iload, 32'h8C01_0004);
        tick();
        idle_inputs();
        mid();
        chk("i_after_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("i_after_iload",  bus.iload, 32'd0);
        tick();

        // Starvation: both held, RAM always ACCESS -> D,D,D,D,I repeating
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0044;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0200;
        bus.ramload  = 32'h0000_5A5A;
        bus.ramstate = RS_ACCESS;
        for (int g = 0; g < 10; g++) begin
            tick();
            mid();
            // {iwait, dwait}: dcache grant -> 2'b10, icache grant -> 2'b01
            chk($sformatf("starve_grant%0d", g), {30'd0, bus.iwait, bus.dwait},
                (g % 5 == 4) ? 32'd1 : 32'd2);
            chk($sformatf("starve_addr%0d", g), bus.ramaddr,
                (g % 5 == 4) ? 32'h0000_0044 : 32'h0000_0200);
            tick();
        end
        idle_inputs();
        tick();

        // LL then successful SC, then failing SC
        bus.ramload = 32'h0000_1234;
        d_xfer(1'b0, 1'b1, 32'h0000_0100, 32'd0);
        mid();
        chk("ll_dwait", {31'd0, bus.dwait}, 32'd0);
        chk("ll_dload", bus.dload, 32'h0000_1234);
        tick();
        idle_inputs();
        d_xfer(1'b1, 1'b1, 32'h0000_0100, 32'h0000_DEAD);
        mid();
        chk("sc1_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
        chk("sc1_ramstore", bus.ramstore, 32'h0000_DEAD);
        chk("sc1_dwait",    {31'd0, bus.dwait},  32'd0);
        chk("sc1_dload",    bus.dload, 32'd1);
        tick();
        idle_inputs();
        d_xfer(1'b1, 1'b1, 32'h0000_0100, 32'h0000_BEEF);
        mid();
        chk("sc2_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("sc2_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("sc2_dwait",  {31'd0, bus.dwait},  32'd0);
        chk("sc2_dload",  bus.dload, 32'd0);
        tick();
        mid();
        chk("sc2_dwait_back", {31'd0, bus.dwait}, 32'd1);
        idle_inputs();
        tick();

        // LL, plain write to same word, SC fails
        d_xfer(1'b0, 1'b1, 32'h0000_0100, 32'd0);
        tick();
        idle_inputs();
        d_xfer(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0077);
        mid();
        chk("pw_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        tick();
        idle_inputs();
        d_xfer(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0088);
        mid();
        chk("sc3_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("sc3_dwait",  {31'd0, bus.dwait},  32'd0);
        chk("sc3_dload",  bus.dload, 32'd0);
        tick();
        idle_inputs();
        tick();

        // dcache read with ERROR x2 then ACCESS
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0300;
        bus.ramload  = 32'hAAAA_5555;
        bus.ramstate = RS_ERROR;
        tick();
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("err_ramREN",  {31'd0, bus.ramREN}, 32'd1);
            chk("err_ramaddr", bus.ramaddr, 32'h0000_0300);
            chk("err_dwait",   {31'd0, bus.dwait},  32'd1);
            chk("err_dload",   bus.dload, 32'd0);
            tick();
        end
        bus.ramstate = RS_ACCESS;
        mid();
        chk("err_acc_ramREN",  {31'd0, bus.ramREN}, 32'd1);
        chk("err_acc_ramaddr", bus.ramaddr, 32'h0000_0300);
        chk("err_acc_dwait",   {31'd0, bus.dwait},  32'd0);
        chk("err_acc_dload",   bus.dload, 32'hAAAA_5555);
        tick();
        idle_inputs();
        tick();

        // Reset mid-DGRANT write clears the link
        d_xfer(1'b0, 1'b1, 32'h0000_0100, 32'd0);
        tick();
        idle_inputs();
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h0000_0500;
        bus.dstore   = 32'h0000_0055;
        bus.ramstate = RS_BUSY;
        tick();
        mid();
        chk("rw_ramWEN_pre", {31'd0, bus.ramWEN}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_ramWEN_rst", {31'd0, bus.ramWEN}, 32'd0);
        chk("rw_dload_rst",  bus.dload, 32'd0);
        tick();
        rst_n = 1'b1;
        idle_inputs();
        tick();
        d_xfer(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0099);
        mid();
        chk("rw_sc_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("rw_sc_dwait",  {31'd0, bus.dwait},  32'd0);
        chk("rw_sc_dload",  bus.dload, 32'd0);
        tick();
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
